// File: rtl/sram_multi_queue_ctrl_if.sv
// Push/pop, SRAM command and read-return signals of the multi-queue SRAM controller.
// The master modport is the surrounding logic (arbiter plus SRAM block); the slave modport is the controller.
interface sram_multi_queue_ctrl_if #(
    parameter int QUEUE_ID_WIDTH = 3,
    parameter int DATA_WIDTH     = 266,
    parameter int MEM_ADDR_WIDTH = 19
);
    logic                      wr_valid;
    logic [QUEUE_ID_WIDTH-1:0] wr_queue_id;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      wr_ready;
    logic                      rd_req;
    logic [QUEUE_ID_WIDTH-1:0] rd_queue_id;
    logic                      rd_ack;
    logic                      sram_write_full;
    logic                      sram_read_full;
    logic                      sram_wr_en;
    logic [MEM_ADDR_WIDTH-1:0] sram_wr_addr;
    logic [DATA_WIDTH-1:0]     sram_wr_data;
    logic                      sram_rd_en;
    logic [MEM_ADDR_WIDTH-1:0] sram_rd_addr;
    logic                      sram_rd_valid;
    logic [DATA_WIDTH-1:0]     sram_rd_data;
    logic                      rd_data_valid;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic [QUEUE_ID_WIDTH-1:0] rd_data_queue_id;

    modport master (
        output wr_valid, wr_queue_id, wr_data, rd_req, rd_queue_id,
               sram_write_full, sram_read_full, sram_rd_valid, sram_rd_data,
        input  wr_ready, rd_ack, sram_wr_en, sram_wr_addr, sram_wr_data,
               sram_rd_en, sram_rd_addr, rd_data_valid, rd_data, rd_data_queue_id
    );

    modport slave (
        input  wr_valid, wr_queue_id, wr_data, rd_req, rd_queue_id,
               sram_write_full, sram_read_full, sram_rd_valid, sram_rd_data,
        output wr_ready, rd_ack, sram_wr_en, sram_wr_addr, sram_wr_data,
               sram_rd_en, sram_rd_addr, rd_data_valid, rd_data, rd_data_queue_id
    );
endinterface

// File: rtl/sram_multi_queue_ctrl.sv
// Pointer/occupancy manager for NUM_QUEUES circular queues sharing one SRAM address space.
// Pushes and pops become SRAM write/read commands; read returns are tagged with their queue id.
module sram_multi_queue_ctrl #(
    parameter int NUM_QUEUES      = 5,
    parameter int QUEUE_ID_WIDTH  = 3,
    parameter int DATA_WIDTH      = 266,
    parameter int MEM_ADDR_WIDTH  = 19,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] q_addr_low,
    input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] q_addr_high,
    input  logic [NUM_QUEUES-1:0]                q_enable,
    sram_multi_queue_ctrl_if.slave               bus,
    output logic [NUM_QUEUES-1:0]                q_empty,
    output logic [NUM_QUEUES-1:0]                q_full,
    output logic [31:0]                          drop_count,
    output logic                                 err_unexpected_rd
);
    localparam int AW = MEM_ADDR_WIDTH;
    localparam int CW = MEM_ADDR_WIDTH + 1;
    localparam int QW = QUEUE_ID_WIDTH;
    localparam int TW = $clog2(MAX_OUTSTANDING);

    logic [AW-1:0] lo_r [NUM_QUEUES];
    logic [AW-1:0] hi_r [NUM_QUEUES];
    logic [AW-1:0] wr_ptr [NUM_QUEUES];
    logic [AW-1:0] rd_ptr [NUM_QUEUES];
    logic [CW-1:0] count [NUM_QUEUES];
    logic [CW-1:0] size [NUM_QUEUES];
    logic [CW-1:0] cnt_next [NUM_QUEUES];

    logic [QW-1:0] tag_mem [MAX_OUTSTANDING];
    logic [TW-1:0] tag_head, tag_tail;
    logic [TW:0]   tag_fill;

    logic          wr_in_range, rd_in_range;
    logic          wr_q_en, wr_q_full, rd_q_en, rd_q_nonempty;
    logic [AW-1:0] wr_sel_ptr, wr_sel_adv, rd_sel_ptr, rd_sel_adv;
    logic          wr_ok, push_fire, push_store, push_drop, ret_pop;

    function automatic logic [AW-1:0] adv(input logic [AW-1:0] ptr, input logic [AW-1:0] lo,
                                          input logic [AW-1:0] hi);
        return (ptr == hi) ? lo : ptr + 1'b1;
    endfunction

    // Per-queue lookups for the addressed push and pop queues; out-of-range ids select nothing.
    always_comb begin
        wr_q_en       = 1'b0;
        wr_q_full     = 1'b0;
        rd_q_en       = 1'b0;
        rd_q_nonempty = 1'b0;
        wr_sel_ptr    = '0;
        wr_sel_adv    = '0;
        rd_sel_ptr    = '0;
        rd_sel_adv    = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            size[i] = {1'b0, hi_r[i]} - {1'b0, lo_r[i]} + 1'b1;
            if (bus.wr_queue_id == QW'(i)) begin
                wr_q_en    = q_enable[i];
                wr_q_full  = (count[i] == size[i]);
                wr_sel_ptr = wr_ptr[i];
                wr_sel_adv = adv(wr_ptr[i], lo_r[i], hi_r[i]);
            end
            if (bus.rd_queue_id == QW'(i)) begin
                rd_q_en       = q_enable[i];
                rd_q_nonempty = (count[i] != '0);
                rd_sel_ptr    = rd_ptr[i];
                rd_sel_adv    = adv(rd_ptr[i], lo_r[i], hi_r[i]);
            end
        end
    end

    assign wr_in_range = int'(bus.wr_queue_id) < NUM_QUEUES;
    assign rd_in_range = int'(bus.rd_queue_id) < NUM_QUEUES;
    assign wr_ok       = wr_in_range & wr_q_en;

    // Push handshake: a word transfers on any cycle with wr_valid & wr_ready; wr_ready never
    // depends on wr_valid. Pops use rd_req/rd_ack where rd_ack is the same-cycle acceptance.
    assign bus.wr_ready = !bus.sram_write_full & !(wr_ok & wr_q_full);
    assign bus.rd_ack   = bus.rd_req & rd_in_range & rd_q_en & rd_q_nonempty & !bus.sram_read_full
                          & (tag_fill < (TW+1)'(MAX_OUTSTANDING));

    assign push_fire  = bus.wr_valid & bus.wr_ready;
    assign push_store = push_fire & wr_ok;
    assign push_drop  = push_fire & !wr_ok;
    assign ret_pop    = bus.sram_rd_valid & (tag_fill != '0);

    always_comb begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            cnt_next[i] = count[i]
                        + CW'(push_store & (bus.wr_queue_id == QW'(i)))
                        - CW'(bus.rd_ack & (bus.rd_queue_id == QW'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                lo_r[i]   <= q_addr_low[i*AW +: AW];
                hi_r[i]   <= q_addr_high[i*AW +: AW];
                wr_ptr[i] <= q_addr_low[i*AW +: AW];
                rd_ptr[i] <= q_addr_low[i*AW +: AW];
                count[i]  <= '0;
            end
            q_empty              <= '1;
            q_full               <= '0;
            tag_head             <= '0;
            tag_tail             <= '0;
            tag_fill             <= '0;
            bus.sram_wr_en       <= 1'b0;
            bus.sram_wr_addr     <= '0;
            bus.sram_wr_data     <= '0;
            bus.sram_rd_en       <= 1'b0;
            bus.sram_rd_addr     <= '0;
            bus.rd_data_valid    <= 1'b0;
            bus.rd_data          <= '0;
            bus.rd_data_queue_id <= '0;
            drop_count           <= '0;
            err_unexpected_rd    <= 1'b0;
        end else begin
            bus.sram_wr_en    <= push_store;
            bus.sram_rd_en    <= bus.rd_ack;
            bus.rd_data_valid <= ret_pop;
            for (int i = 0; i < NUM_QUEUES; i++) begin
                count[i]   <= cnt_next[i];
                q_empty[i] <= (cnt_next[i] == '0);
                q_full[i]  <= (cnt_next[i] == size[i]);
                if (push_store && bus.wr_queue_id == QW'(i)) wr_ptr[i] <= wr_sel_adv;
                if (bus.rd_ack && bus.rd_queue_id == QW'(i)) rd_ptr[i] <= rd_sel_adv;
            end
            if (push_store) begin
                bus.sram_wr_addr <= wr_sel_ptr;
                bus.sram_wr_data <= bus.wr_data;
            end
            if (push_drop && drop_count != 32'hffff_ffff) drop_count <= drop_count + 1'b1;
            if (bus.rd_ack) begin
                bus.sram_rd_addr  <= rd_sel_ptr;
                tag_mem[tag_tail] <= bus.rd_queue_id;
                tag_tail          <= tag_tail + 1'b1;
            end
            if (ret_pop) begin
                bus.rd_data          <= bus.sram_rd_data;
                bus.rd_data_queue_id <= tag_mem[tag_head];
                tag_head             <= tag_head + 1'b1;
            end
            if (bus.sram_rd_valid && tag_fill == '0) err_unexpected_rd <= 1'b1;
            tag_fill <= tag_fill + (TW+1)'(bus.rd_ack) - (TW+1)'(ret_pop);
        end
    end
endmodule

// File: tb/tb_sram_multi_queue_ctrl.sv
// Bench for sram_multi_queue_ctrl: directed scenarios plus a random phase, each cycle checked
// against an arithmetic per-queue model with a queue of expected return tags.
module tb_sram_multi_queue_ctrl;
    localparam int N  = 5;
    localparam int QW = 3;
    localparam int DW = 266;
    localparam int AW = 19;
    localparam int MO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N*AW-1:0] q_addr_low, q_addr_high;
    logic [N-1:0]  q_enable, q_empty, q_full;
    logic [31:0]   drop_count;
    logic          err_unexpected_rd;

    sram_multi_queue_ctrl_if #(.QUEUE_ID_WIDTH(QW), .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW)) bus ();

    sram_multi_queue_ctrl #(
        .NUM_QUEUES(N), .QUEUE_ID_WIDTH(QW), .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset(reset), .q_addr_low(q_addr_low), .q_addr_high(q_addr_high),
        .q_enable(q_enable), .bus(bus), .q_empty(q_empty), .q_full(q_full),
        .drop_count(drop_count), .err_unexpected_rd(err_unexpected_rd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          lo [N] = '{0, 4, 8, 12, 20};
    int          hi [N] = '{3, 7, 11, 19, 20};
    bit          en [N];
    int          m_cnt [N];
    int          m_wp [N];
    int          m_rp [N];
    logic [QW-1:0] exp_q[$];
    logic [31:0] m_drops;
    bit          m_err;

    function automatic int qsize(input int q);
        return hi[q] - lo[q] + 1;
    endfunction

    function automatic int adv(input int p, input int q);
        return lo[q] + ((p - lo[q] + 1) % qsize(q));
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d = '0;
        for (int k = 0; k < 9; k++) d = {d[DW-33:0], 32'($urandom())};
        return d;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_en(input int q, input bit v);
        en[q] = v;
        q_enable[q] = v;
    endtask

    task automatic idle();
        bus.wr_valid = 1'b0; bus.wr_queue_id = '0; bus.wr_data = '0;
        bus.rd_req = 1'b0; bus.rd_queue_id = '0;
        bus.sram_write_full = 1'b0; bus.sram_read_full = 1'b0;
        bus.sram_rd_valid = 1'b0; bus.sram_rd_data = '0;
    endtask

    task automatic model_reset();
        for (int q = 0; q < N; q++) begin
            m_wp[q] = lo[q]; m_rp[q] = lo[q]; m_cnt[q] = 0;
        end
        exp_q.delete();
        m_drops = '0;
        m_err = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        @(posedge clk); #1;
        model_reset();
        chk("rst_wr_en", DW'(bus.sram_wr_en), DW'(0));
        chk("rst_wr_addr", DW'(bus.sram_wr_addr), DW'(0));
        chk("rst_rd_en", DW'(bus.sram_rd_en), DW'(0));
        chk("rst_rd_addr", DW'(bus.sram_rd_addr), DW'(0));
        chk("rst_rd_valid", DW'(bus.rd_data_valid), DW'(0));
        chk("rst_empty", DW'(q_empty), DW'(5'b11111));
        chk("rst_full", DW'(q_full), DW'(0));
        chk("rst_drops", DW'(drop_count), DW'(0));
        chk("rst_err", DW'(err_unexpected_rd), DW'(0));
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock with the inputs already applied: checks the combinational handshakes, advances the
    // model, then checks every registered output just after the edge.
    task automatic cycle();
        int wi, ri;
        bit p_ready, p_ack, e_wr_en, e_rd_en, e_rdv;
        int e_wa, e_ra;
        logic [DW-1:0] e_wd, e_rd;
        logic [QW-1:0] e_tag;
        logic [N-1:0] e_empty, e_full;
        #1;
        wi = int'(bus.wr_queue_id);
        ri = int'(bus.rd_queue_id);
        p_ready = !bus.sram_write_full && !(wi < N && en[wi] && m_cnt[wi] == qsize(wi));
        p_ack = bus.rd_req && ri < N && en[ri] && m_cnt[ri] != 0 && !bus.sram_read_full
                && exp_q.size() < MO;
        chk("wr_ready", DW'(bus.wr_ready), DW'(p_ready));
        chk("rd_ack", DW'(bus.rd_ack), DW'(p_ack));
        e_wr_en = 1'b0; e_wa = 0; e_wd = '0;
        if (bus.wr_valid && p_ready) begin
            if (wi < N && en[wi]) begin
                e_wr_en = 1'b1; e_wa = m_wp[wi]; e_wd = bus.wr_data;
                m_wp[wi] = adv(m_wp[wi], wi);
                m_cnt[wi]++;
            end else if (m_drops != 32'hffff_ffff) begin
                m_drops++;
            end
        end
        e_rdv = 1'b0; e_tag = '0; e_rd = '0;
        if (bus.sram_rd_valid) begin
            if (exp_q.size() > 0) begin
                e_rdv = 1'b1; e_tag = exp_q.pop_front(); e_rd = bus.sram_rd_data;
            end else begin
                m_err = 1'b1;
            end
        end
        e_rd_en = 1'b0; e_ra = 0;
        if (p_ack) begin
            e_rd_en = 1'b1; e_ra = m_rp[ri];
            m_rp[ri] = adv(m_rp[ri], ri);
            m_cnt[ri]--;
            exp_q.push_back(QW'(ri));
        end
        for (int q = 0; q < N; q++) begin
            e_empty[q] = (m_cnt[q] == 0);
            e_full[q]  = (m_cnt[q] == qsize(q));
        end
        @(posedge clk); #1;
        chk("sram_wr_en", DW'(bus.sram_wr_en), DW'(e_wr_en));
        if (e_wr_en) begin
            chk("sram_wr_addr", DW'(bus.sram_wr_addr), DW'(e_wa));
            chk("sram_wr_data", bus.sram_wr_data, e_wd);
        end
        chk("sram_rd_en", DW'(bus.sram_rd_en), DW'(e_rd_en));
        if (e_rd_en) chk("sram_rd_addr", DW'(bus.sram_rd_addr), DW'(e_ra));
        chk("rd_data_valid", DW'(bus.rd_data_valid), DW'(e_rdv));
        if (e_rdv) begin
            chk("rd_data", bus.rd_data, e_rd);
            chk("rd_data_queue_id", DW'(bus.rd_data_queue_id), DW'(e_tag));
        end
        chk("q_empty", DW'(q_empty), DW'(e_empty));
        chk("q_full", DW'(q_full), DW'(e_full));
        chk("drop_count", DW'(drop_count), DW'(m_drops));
        chk("err_unexpected_rd", DW'(err_unexpected_rd), DW'(m_err));
        @(negedge clk);
    endtask

    task automatic step(input bit wv, input int wq, input bit rv, input int rq, input bit sv,
                        input bit wfull = 1'b0, input bit rfull = 1'b0);
        bus.wr_valid = wv; bus.wr_queue_id = QW'(wq); bus.wr_data = rnd_data();
        bus.rd_req = rv; bus.rd_queue_id = QW'(rq);
        bus.sram_rd_valid = sv; bus.sram_rd_data = rnd_data();
        bus.sram_write_full = wfull; bus.sram_read_full = rfull;
        cycle();
        idle();
    endtask

    task automatic drain();
        for (int k = 0; k < MO && exp_q.size() > 0; k++) step(0, 0, 0, 0, 1);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        for (int q = 0; q < N; q++) begin
            q_addr_low[q*AW +: AW]  = AW'(lo[q]);
            q_addr_high[q*AW +: AW] = AW'(hi[q]);
            set_en(q, 1'b1);
        end
        @(negedge clk);
        do_reset();

        // Fill q0 (addresses 0..3), then a fifth push must stall
        repeat (4) step(1, 0, 0, 0, 0);
        chk("q0_full_after_4", DW'(q_full[0]), DW'(1));
        step(1, 0, 0, 0, 0);

        // Pop all four, push two that wrap back to 0,1
        repeat (4) step(0, 0, 1, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0);
        chk("q0_wrap_addr", DW'(bus.sram_wr_addr), DW'(1));
        chk("q0_not_empty", DW'(q_empty[0]), DW'(0));
        drain();

        // Simultaneous push and pop on q1 holding one word
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 0);
        chk("both_wr_en", DW'(bus.sram_wr_en), DW'(1));
        chk("both_rd_en", DW'(bus.sram_rd_en), DW'(1));
        chk("q1_still_one", DW'({q_full[1], q_empty[1]}), DW'(0));
        drain();

        // Outstanding-read limit
        repeat (8) step(1, 3, 0, 0, 0);
        repeat (8) step(0, 0, 1, 3, 0);
        bus.rd_req = 1'b1; bus.rd_queue_id = 3'd0;
        #1 chk("ninth_pop_blocked", DW'(bus.rd_ack), DW'(0));
        cycle();
        idle();
        step(0, 0, 0, 0, 1);
        chk("first_tag_q3", DW'(bus.rd_data_queue_id), DW'(3));
        step(0, 0, 1, 0, 0);
        chk("pop_after_return", DW'(bus.sram_rd_en), DW'(1));
        drain();

        // Disabled queue drops pushes and refuses pops
        set_en(2, 1'b0);
        repeat (3) step(1, 2, 0, 0, 0);
        chk("drop_count_3", DW'(drop_count), DW'(3));
        step(0, 0, 1, 2, 0);
        set_en(2, 1'b1);

        // Single-word q4: pop-while-empty with push, then push-while-full with pop
        step(1, 4, 1, 4, 0);
        step(1, 4, 1, 4, 0);
        drain();

        // Backpressure and out-of-range ids
        step(1, 1, 0, 0, 0, 1, 0);
        step(1, 6, 1, 0, 0, 0, 1);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 49) begin
                int t = $urandom_range(0, N - 1);
                set_en(t, !en[t]);
            end
            step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 7), exp_q.size() > 0 && $urandom_range(0, 2) != 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end
        for (int q = 0; q < N; q++) set_en(q, 1'b1);
        drain();

        // Return with nothing outstanding
        step(0, 0, 0, 0, 1);
        chk("unexpected_err", DW'(err_unexpected_rd), DW'(1));
        chk("unexpected_no_valid", DW'(bus.rd_data_valid), DW'(0));

        // Reset mid-operation clears flags and rewinds pointers
        step(1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        do_reset();
        step(0, 0, 0, 0, 1);
        chk("late_return_err", DW'(err_unexpected_rd), DW'(1));
        do_reset();
        step(1, 0, 0, 0, 0);
        chk("ptr_rewound_wr", DW'(bus.sram_wr_addr), DW'(0));
        step(0, 0, 1, 0, 0);
        chk("ptr_rewound_rd", DW'(bus.sram_rd_addr), DW'(0));
        step(1, 1, 0, 0, 0);
        chk("q1_rewound_wr", DW'(bus.sram_wr_addr), DW'(4));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_multi_queue_ctrl.md
Name: sram_multi_queue_ctrl

Overview:
Parametrised pointer/occupancy manager for N circular queues carved out of one external SRAM address space. Sits between the output-queue arbiter and the SRAM interface block. Converts per-queue write pushes and read pops into SRAM write/read commands, and tags read returns with their queue id. Adds per-queue occupancy counters, outstanding-read tracking, disabled-queue drop and error flags.

Parameters:
NUM_QUEUES, 5, number of queues
QUEUE_ID_WIDTH, 3, queue id width; must satisfy 2**QUEUE_ID_WIDTH >= NUM_QUEUES
DATA_WIDTH, 266, payload word width (8*TDATA_WIDTH+10)
MEM_ADDR_WIDTH, 19, SRAM word address width
MAX_OUTSTANDING, 8, maximum SRAM reads in flight; power of 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
q_addr_low  in  NUM_QUEUES*MEM_ADDR_WIDTH  first word of queue i, slice i
q_addr_high  in  NUM_QUEUES*MEM_ADDR_WIDTH  last word of queue i (inclusive)
q_enable  in  NUM_QUEUES  per-queue enable
wr_valid  in  1  push request
wr_queue_id  in  QUEUE_ID_WIDTH  push target queue
wr_data  in  DATA_WIDTH  push word
wr_ready  out  1  push accepted when wr_valid & wr_ready
rd_req  in  1  pop request
rd_queue_id  in  QUEUE_ID_WIDTH  pop source queue
rd_ack  out  1  pop accepted this cycle (combinational)
sram_write_full  in  1  SRAM write path backpressure
sram_read_full  in  1  SRAM read path backpressure
sram_wr_en  out  1  write command strobe
sram_wr_addr  out  MEM_ADDR_WIDTH  write address
sram_wr_data  out  DATA_WIDTH  write data
sram_rd_en  out  1  read command strobe
sram_rd_addr  out  MEM_ADDR_WIDTH  read address
sram_rd_valid  in  1  read data return, in command order
sram_rd_data  in  DATA_WIDTH  returned word
rd_data_valid  out  1  returned word valid
rd_data  out  DATA_WIDTH  returned word
rd_data_queue_id  out  QUEUE_ID_WIDTH  queue of returned word
q_empty  out  NUM_QUEUES  occupancy == 0
q_full  out  NUM_QUEUES  occupancy == region size
drop_count  out  32  words discarded for disabled queues
err_unexpected_rd  out  1  sticky: sram_rd_valid with no read outstanding

Behaviour:
- Reset (reset==0 at a clk edge): wr_ptr[i] and rd_ptr[i] load q_addr_low[i]. count[i]=0. Tag FIFO cleared. All command/valid outputs=0. Addr/data outputs=0. drop_count=0. err_unexpected_rd=0. q_empty=all 1, q_full=0. Region bounds are registered only during reset; they are held constant afterwards.
- Region size: size[i]=high-low+1. count is MEM_ADDR_WIDTH+1 bits wide.
- Pointer advance: if ptr==high[i], ptr becomes low[i]; otherwise ptr becomes ptr+1.
- wr_ready = !sram_write_full & (id>=NUM_QUEUES | !q_enable[id] | count[id]!=size[id]).
- Push accept, enabled valid queue: at the next edge, sram_wr_en=1, sram_wr_addr=old wr_ptr, sram_wr_data=wr_data; wr_ptr advances.
- Push accept, disabled or out-of-range queue: word is discarded, drop_count increments (saturating), and no SRAM command is issued.
- rd_ack = rd_req & id<NUM_QUEUES & q_enable[id] & count[id]!=0 & !sram_read_full & outstanding<MAX_OUTSTANDING.
- On rd_ack, at the next edge: sram_rd_en=1, sram_rd_addr=old rd_ptr; rd_ptr advances; id is pushed to the tag FIFO.
- Requests not acknowledged have no side effects.
- Occupancy: count +1 on enabled push accept and -1 on rd_ack. If both hit the same queue in one cycle, count is unchanged. Both events are legal in one cycle.
- Pop-while-empty: not acked, even if a push to that queue is accepted in the same cycle. Push-while-full is not accepted, even if a pop occurs the same cycle.
- q_empty/q_full are registered and reflect count after each edge. wr_ready and rd_ack are derived from the registered count.
- Returns: on sram_rd_valid, the tag FIFO head is popped. At the next edge: rd_data_valid=1, rd_data=sram_rd_data, rd_data_queue_id=head. Consumer has no backpressure.
- outstanding = tag FIFO fill. A tag pushed and another popped in the same cycle leave the fill unchanged.
- sram_rd_valid with an empty tag FIFO: return dropped, rd_data_valid=0, err_unexpected_rd set until reset.
- Reset mid-operation: in-flight tags are discarded. Returns arriving after reset raise err_unexpected_rd.

Test Plan:
- Regions q0=[0,3], q1=[4,7]; push 4 words to q0 -> sram_wr_addr 0,1,2,3; q_full[0]=1; 5th push sees wr_ready=0.
- q0 full, then pop 4 and push 2 -> pops read 0,1,2,3; pushes write 0,1 (wrap); final count=2; q_empty[0]=0.
- Push q1 and pop q1 in the same cycle, count=1 -> count stays 1; sram_wr_en and sram_rd_en both asserted the following cycle.
- 8 pops with sram_rd_valid withheld -> 9th rd_req gets rd_ack=0. Return 1 word -> rd_data_queue_id matches the first tag; the next pop is acked.
- q_enable[2]=0; push 3 words to q2 -> wr_ready=1, no sram_wr_en, drop_count=3; pop of q2 -> rd_ack=0.
- sram_rd_valid with nothing outstanding -> err_unexpected_rd=1 and rd_data_valid=0; reset low one cycle -> flags cleared, pointers back at low.
